// File: rtl/avr_pp_pkg.sv
// rtl/avr_pp_pkg.sv - shared encodings for the AVR parallel-programming sequencer
package avr_pp_pkg;

    typedef enum logic [2:0] {
        OP_LOAD_CMD  = 3'd0,
        OP_LOAD_ADDR = 3'd1,
        OP_LOAD_DATA = 3'd2,
        OP_PAGEL     = 3'd3,
        OP_WRITE     = 3'd4,
        OP_READ      = 3'd5
    } op_e;

    localparam logic [2:0] OP_LAST_VALID = 3'd5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_BSY_WAIT,
        ST_RDY_WAIT,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FIN
    } state_e;

    // {xa1, xa0} pin pairs selecting what the next XTAL1 pulse loads
    localparam logic [1:0] XA_ADDR = 2'b00;
    localparam logic [1:0] XA_DATA = 2'b01;
    localparam logic [1:0] XA_CMD  = 2'b10;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/avr_pp_sequencer_sync2.sv
// rtl/avr_pp_sequencer_sync2.sv - two-flop synchroniser for one asynchronous pin
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/avr_pp_sequencer.sv
// rtl/avr_pp_sequencer.sv - turns single host operations into timed HV parallel-programming pin waveforms
module avr_pp_sequencer
    import avr_pp_pkg::*;
#(
    parameter int XTAL_W  = 4,
    parameter int SETUP_W = 2,
    parameter int WR_W    = 4,
    parameter int OE_W    = 6,
    parameter int BSY_W   = 8,
    parameter int TMO_W   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       sel_bs1,
    input  logic       sel_bs2,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    input  logic       dut_rdy,
    input  logic [7:0] dut_din,
    output logic       dut_xtal,
    output logic       dut_pagel,
    output logic       dut_xa0,
    output logic       dut_xa1,
    output logic       dut_bs1,
    output logic       dut_bs2,
    output logic       dut_wr_n,
    output logic       dut_oe_n,
    output logic [7:0] dut_dout,
    output logic       dut_dout_en
);

    localparam int CNT_MAX = max_of(max_of(XTAL_W, SETUP_W), max_of(max_of(WR_W, OE_W), BSY_W));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Reaching this value means the next increment would saturate the timeout counter
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic       rdy_s;
    logic [7:0] din_s;

    sync2 u_sync_rdy (.clk(clk), .rst_n(rst_n), .d_i(dut_rdy), .q_o(rdy_s));

    for (genvar b = 0; b < 8; b++) begin : g_din_sync
        sync2 u_sync_din (.clk(clk), .rst_n(rst_n), .d_i(dut_din[b]), .q_o(din_s[b]));
    end

    state_e           state_q;
    op_e              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic             busy_q, done_q, err_q;
    logic [7:0]       rdata_q;
    logic             xtal_q, pagel_q, xa0_q, xa1_q, bs1_q, bs2_q;
    logic             wr_n_q, oe_n_q;
    logic [7:0]       dout_q;
    logic             dout_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD_CMD;
            cnt_q     <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 8'h00;
            xtal_q    <= 1'b0;
            pagel_q   <= 1'b0;
            xa0_q     <= 1'b0;
            xa1_q     <= 1'b0;
            bs1_q     <= 1'b0;
            bs2_q     <= 1'b0;
            wr_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            dout_q    <= 8'h00;
            dout_en_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (op > OP_LAST_VALID) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            busy_q  <= 1'b1;
                            op_q    <= op_e'(op);
                            bs1_q   <= sel_bs1;
                            bs2_q   <= sel_bs2;
                            cnt_q   <= CNT_W'(SETUP_W);
                            state_q <= ST_SETUP;
                            case (op_e'(op))
                                OP_LOAD_CMD:  {xa1_q, xa0_q} <= XA_CMD;
                                OP_LOAD_ADDR: {xa1_q, xa0_q} <= XA_ADDR;
                                OP_LOAD_DATA: {xa1_q, xa0_q} <= XA_DATA;
                                default: ;
                            endcase
                            if (op_e'(op) inside {OP_LOAD_CMD, OP_LOAD_ADDR, OP_LOAD_DATA}) begin
                                dout_q    <= wdata;
                                dout_en_q <= 1'b1;
                            end
                            // Release the bus first; /OE falls on the following edge
                            if (op_e'(op) == OP_READ) begin
                                dout_en_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    if (op_q == OP_READ) begin
                        oe_n_q <= 1'b0;
                    end
                    if (cnt_q <= CNT_ONE) begin
                        case (op_q)
                            OP_READ: begin
                                cnt_q   <= CNT_W'(OE_W);
                                state_q <= ST_SETTLE;
                            end
                            OP_WRITE: begin
                                wr_n_q  <= 1'b0;
                                cnt_q   <= CNT_W'(WR_W);
                                state_q <= ST_STROBE;
                            end
                            OP_PAGEL: begin
                                pagel_q <= 1'b1;
                                cnt_q   <= CNT_W'(XTAL_W);
                                state_q <= ST_STROBE;
                            end
                            default: begin
                                xtal_q  <= 1'b1;
                                cnt_q   <= CNT_W'(XTAL_W);
                                state_q <= ST_STROBE;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q <= CNT_ONE) begin
                        xtal_q  <= 1'b0;
                        pagel_q <= 1'b0;
                        if (op_q == OP_WRITE) begin
                            wr_n_q  <= 1'b1;
                            cnt_q   <= CNT_W'(BSY_W);
                            state_q <= ST_BSY_WAIT;
                        end else begin
                            cnt_q   <= CNT_W'(SETUP_W);
                            state_q <= ST_HOLD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q <= CNT_ONE) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_BSY_WAIT: begin
                    // A part that never drops RDY finished the write faster than we could see
                    if (!rdy_s) begin
                        tmo_q   <= '0;
                        state_q <= ST_RDY_WAIT;
                    end else if (cnt_q <= CNT_ONE) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RDY_WAIT: begin
                    if (rdy_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_SAMPLE: begin
                    rdata_q <= din_s;
                    oe_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_FIN;
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign dut_xtal    = xtal_q;
    assign dut_pagel   = pagel_q;
    assign dut_xa0     = xa0_q;
    assign dut_xa1     = xa1_q;
    assign dut_bs1     = bs1_q;
    assign dut_bs2     = bs2_q;
    assign dut_wr_n    = wr_n_q;
    assign dut_oe_n    = oe_n_q;
    assign dut_dout    = dout_q;
    assign dut_dout_en = dout_en_q;

endmodule

// File: tb/tb_avr_pp_sequencer.sv
// tb/tb_avr_pp_sequencer.sv - scoreboard bench for the parallel-programming sequencer
module tb_avr_pp_sequencer;

    localparam int XTAL_W  = 4;
    localparam int SETUP_W = 2;
    localparam int WR_W    = 4;
    localparam int OE_W    = 6;
    localparam int BSY_W   = 8;
    localparam int TMO_W   = 7;
    localparam int TMO_CYC = (1 << TMO_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic       sel_bs1 = 1'b0;
    logic       sel_bs2 = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       busy, done, err;
    logic [7:0] rdata;
    logic       dut_rdy = 1'b1;
    logic [7:0] dut_din = 8'h00;
    logic       dut_xtal, dut_pagel, dut_xa0, dut_xa1, dut_bs1, dut_bs2;
    logic       dut_wr_n, dut_oe_n;
    logic [7:0] dut_dout;
    logic       dut_dout_en;

    avr_pp_sequencer #(
        .XTAL_W(XTAL_W), .SETUP_W(SETUP_W), .WR_W(WR_W),
        .OE_W(OE_W), .BSY_W(BSY_W), .TMO_W(TMO_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .sel_bs1(sel_bs1), .sel_bs2(sel_bs2), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .dut_rdy(dut_rdy), .dut_din(dut_din),
        .dut_xtal(dut_xtal), .dut_pagel(dut_pagel), .dut_xa0(dut_xa0), .dut_xa1(dut_xa1),
        .dut_bs1(dut_bs1), .dut_bs2(dut_bs2), .dut_wr_n(dut_wr_n), .dut_oe_n(dut_oe_n),
        .dut_dout(dut_dout), .dut_dout_en(dut_dout_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         s_cyc;
        int         lat_min;
        int         lat_max;
        logic       err;
        logic [1:0] xa;
        logic [1:0] bs;
        logic       dout_en;
        logic       chk_dout;
        logic [7:0] dout;
        logic       chk_rd;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_push = 0;
    int   done_cnt = 0;
    int   rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input int lmin, input int lmax, input logic er, input logic [1:0] xa,
                                input logic [1:0] bs, input logic den, input logic cd, input logic [7:0] d,
                                input logic cr, input logic [7:0] r);
        exp_t e;
        e.s_cyc = 0; e.lat_min = lmin; e.lat_max = lmax; e.err = er; e.xa = xa; e.bs = bs;
        e.dout_en = den; e.chk_dout = cd; e.dout = d; e.chk_rd = cr; e.rdata = r;
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic b1, input logic b2, input logic [7:0] wd,
                         input exp_t e, input bit push);
        @(negedge clk);
        op = o; sel_bs1 = b1; sel_bs2 = b2; wdata = wd; start = 1'b1;
        e.s_cyc = cyc;
        if (push) begin
            sb.push_back(e);
            n_push++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle", nm, busy, sb.size());
        end
    endtask

    // Scoreboard monitor: every done pulse retires the oldest expected operation
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op");
                end else begin
                    e = sb.pop_front();
                    lat = cyc - e.s_cyc + 1;
                    n_chk++;
                    if (lat < e.lat_min || lat > e.lat_max) begin
                        n_err++;
                        $display("FAIL latency: got %0d expected %0d..%0d", lat, e.lat_min, e.lat_max);
                    end
                    chk("err", err, e.err);
                    chk("xa", {dut_xa1, dut_xa0}, e.xa);
                    chk("bs", {dut_bs1, dut_bs2}, e.bs);
                    chk("dout_en", dut_dout_en, e.dout_en);
                    chk("fin_pins", {busy, dut_xtal, dut_pagel, dut_wr_n, dut_oe_n}, 5'b00011);
                    if (e.chk_dout) chk("dout", dut_dout, e.dout);
                    if (e.chk_rd) chk("rdata", rdata, e.rdata);
                end
            end
        end
    end

    // Pin-level timing monitor
    initial begin
        int   xt_run = 0, pg_run = 0, wr_run = 0, stab = 0;
        logic p_xtal = 1'b0, p_oe = 1'b1, p_den = 1'b0;
        logic [7:0] p_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                xt_run = 0; pg_run = 0; wr_run = 0; stab = 0;
            end else begin
                if (dut_dout_en && dut_dout == p_dout) stab++;
                else stab = 1;
                if (dut_xtal && !p_xtal) chk("dout_setup_before_xtal", (stab > SETUP_W), 1);
                if (dut_xtal) xt_run++;
                else if (xt_run != 0) begin chk("xtal_width", xt_run, XTAL_W); xt_run = 0; end
                if (dut_pagel) pg_run++;
                else if (pg_run != 0) begin chk("pagel_width", pg_run, XTAL_W); pg_run = 0; end
                if (!dut_wr_n) wr_run++;
                else if (wr_run != 0) begin chk("wr_width", wr_run, WR_W); wr_run = 0; end
                if (!dut_oe_n && p_oe) begin
                    chk("dout_en_off_before_oe", p_den, 0);
                    chk("dout_en_off_at_oe", dut_dout_en, 0);
                end
            end
            p_xtal = dut_xtal; p_oe = dut_oe_n; p_den = dut_dout_en; p_dout = dut_dout;
        end
    end

    // RDY model: in mode 1, drops RDY 3 cycles after /WR rises and holds it low for 100 cycles
    initial begin
        logic p_wr = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode == 1 && dut_wr_n && !p_wr) begin
                repeat (3) @(negedge clk);
                dut_rdy = 1'b0;
                repeat (100) @(negedge clk);
                dut_rdy = 1'b1;
                rdy_mode = 0;
            end
            p_wr = dut_wr_n;
        end
    end

    initial begin
        bit seen;
        int lat_ld, lat_wr, lat_rd;
        lat_ld = 1 + SETUP_W + XTAL_W + SETUP_W + 1;
        lat_wr = 1 + SETUP_W + WR_W + BSY_W + 1;
        lat_rd = 1 + SETUP_W + OE_W + 1 + 1;

        repeat (3) @(negedge clk);
        chk("reset_ctl", {busy, done, err, dut_xtal, dut_pagel, dut_xa1, dut_xa0, dut_bs1, dut_bs2,
                          dut_wr_n, dut_oe_n, dut_dout_en}, 12'b000000000110);
        chk("reset_data", {rdata, dut_dout}, 16'h0000);
        rst_n = 1'b1;

        issue(3'd0, 1'b0, 1'b0, 8'h10, mk(lat_ld, lat_ld, 0, 2'b10, 2'b00, 1, 1, 8'h10, 0, 8'h00), 1);
        wait_idle("load_cmd");
        issue(3'd1, 1'b1, 1'b0, 8'h3C, mk(lat_ld, lat_ld, 0, 2'b00, 2'b10, 1, 1, 8'h3C, 0, 8'h00), 1);
        wait_idle("load_addr");
        issue(3'd2, 1'b0, 1'b1, 8'h5A, mk(lat_ld, lat_ld, 0, 2'b01, 2'b01, 1, 1, 8'h5A, 0, 8'h00), 1);
        wait_idle("load_data");
        issue(3'd3, 1'b0, 1'b0, 8'hEE, mk(lat_ld, lat_ld, 0, 2'b01, 2'b00, 1, 1, 8'h5A, 0, 8'h00), 1);
        wait_idle("pagel");

        issue(3'd4, 1'b0, 1'b0, 8'h00, mk(lat_wr, lat_wr, 0, 2'b01, 2'b00, 1, 1, 8'h5A, 0, 8'h00), 1);
        wait_idle("write_instant");

        rdy_mode = 1;
        issue(3'd4, 1'b1, 1'b1, 8'h00, mk(112, 116, 0, 2'b01, 2'b11, 1, 1, 8'h5A, 0, 8'h00), 1);
        wait_idle("write_rdy");

        dut_rdy = 1'b0;
        issue(3'd4, 1'b0, 1'b0, 8'h00,
              mk(1 + SETUP_W + WR_W + 1 + TMO_CYC + 1, 1 + SETUP_W + WR_W + 1 + TMO_CYC + 1,
                 1, 2'b01, 2'b00, 1, 1, 8'h5A, 0, 8'h00), 1);
        wait_idle("write_timeout");
        dut_rdy = 1'b1;

        issue(3'd0, 1'b0, 1'b0, 8'h02, mk(lat_ld, lat_ld, 0, 2'b10, 2'b00, 1, 1, 8'h02, 0, 8'h00), 1);
        chk("err_cleared_on_start", err, 0);
        @(negedge clk);
        op = 3'd2; wdata = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("start_while_busy");

        dut_din = 8'hA5;
        issue(3'd5, 1'b1, 1'b0, 8'h00, mk(lat_rd, lat_rd, 0, 2'b10, 2'b10, 0, 0, 8'h00, 1, 8'hA5), 1);
        wait_idle("read");

        issue(3'd6, 1'b0, 1'b1, 8'h99, mk(2, 2, 1, 2'b10, 2'b10, 0, 0, 8'h00, 1, 8'hA5), 1);
        wait_idle("reserved_op");

        issue(3'd1, 1'b0, 1'b0, 8'h77, mk(lat_ld, lat_ld, 0, 2'b00, 2'b00, 1, 1, 8'h77, 0, 8'h00), 1);
        wait_idle("load_before_abort");
        issue(3'd4, 1'b0, 1'b0, 8'h00, mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 8'h00, 0, 8'h00), 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!dut_wr_n) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_wr_low_seen", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_pins", {dut_wr_n, dut_oe_n, busy, done, dut_dout_en}, 5'b11000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_idle", {busy, err, dut_wr_n}, 3'b001);
        chk("done_count", done_cnt, n_push);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
